// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding, register map and field layouts for the DMA controller
package dma_pkg;
    localparam int NCH = 4;
    localparam int AW = 16;
    typedef enum logic [2:0] {SI, S0, S1, S2, S4} state_t;
    localparam logic [3:0] R_ADDR0 = 4'h0, R_CNT0 = 4'h1, R_ADDR1 = 4'h2, R_CNT1 = 4'h3;
    localparam logic [3:0] R_ADDR2 = 4'h4, R_CNT2 = 4'h5, R_ADDR3 = 4'h6, R_CNT3 = 4'h7;
    localparam logic [3:0] R_CMD = 4'h8, R_REQ = 4'h9, R_SMASK = 4'hA, R_MODE = 4'hB;
    localparam logic [3:0] R_CLRFF = 4'hC, R_MCLR = 4'hD, R_CLRMASK = 4'hE, R_MASK = 4'hF;
    typedef enum logic [1:0] {XF_VERIFY = 2'b00, XF_WRITE = 2'b01, XF_READ = 2'b10, XF_ILLEGAL = 2'b11} xfer_t;
    typedef struct packed {
        logic [1:0] kind;
        logic       dec;
        logic       autoinit;
        xfer_t      xfer;
        logic [1:0] ch;
    } mode_t;
    typedef struct packed {
        logic [4:0] hi;
        logic       ctrl_off;
        logic [1:0] lo;
    } cmd_t;
    function automatic logic [1:0] onehot_idx(input logic [NCH-1:0] g);
        onehot_idx = '0;
        for (int i = 0; i < NCH; i++) if (g[i]) onehot_idx = 2'(i);
    endfunction
endpackage

// File: rtl/dma_modport_if.sv
// dma_modport_if: CPU/system bus of the DMA controller; bidirectional pins split into value, drive and enable
interface dma_modport_if;
    import dma_pkg::*;
    logic           cs_n, ior_n, iow_n, eop_n, hlda;
    logic [7:0]     db;
    logic [3:0]     addr_l;
    logic [NCH-1:0] dreq;
    logic           ior_n_drv, iow_n_drv, io_oe;
    logic [7:0]     db_drv;
    logic           db_oe;
    logic [3:0]     addr_l_drv;
    logic           addr_l_oe, eop_oe;
    logic [3:0]     addr_u;
    logic [NCH-1:0] dack;
    logic           hrq, aen, adstb, memr_n, memw_n;
    modport master (
        input  cs_n, ior_n, iow_n, eop_n, hlda, db, addr_l, dreq,
        output ior_n_drv, iow_n_drv, io_oe, db_drv, db_oe, addr_l_drv, addr_l_oe, eop_oe,
        output addr_u, dack, hrq, aen, adstb, memr_n, memw_n
    );
    modport slave (
        output cs_n, ior_n, iow_n, eop_n, hlda, db, addr_l, dreq,
        input  ior_n_drv, iow_n_drv, io_oe, db_drv, db_oe, addr_l_drv, addr_l_oe, eop_oe,
        input  addr_u, dack, hrq, aen, adstb, memr_n, memw_n
    );
endinterface

// File: rtl/dma_priority.sv
// dma_priority: fixed-priority arbiter, lowest-numbered request wins
module dma_priority #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] grant
);
    assign grant = req & (~req + 1'b1);
endmodule

// File: rtl/dma_modport.sv
// dma_modport: four-channel 8237A-style DMA controller (register file, timing FSM, datapath)
module dma_modport
    import dma_pkg::*;
(
    input logic CLK,
    input logic RESET,
    dma_modport_if.master bus
);
    state_t state, state_nx;
    cmd_t cmd;
    mode_t mode [NCH];
    mode_t m;
    logic [AW-1:0] base_addr [NCH];
    logic [AW-1:0] cur_addr [NCH];
    logic [AW-1:0] base_cnt [NCH];
    logic [AW-1:0] cur_cnt [NCH];
    logic [AW-1:0] addr, rd_word;
    logic [NCH-1:0] mask, softreq, tc, active, grant;
    logic [7:0] rd_data;
    logic [3:0] rd_sel;
    logic [1:0] ch, wch;
    logic ff, wr_q, rd_q, abort, eop_ext;
    logic slave_sel, wr_lvl, rd_lvl, wr_go, rd_end, mclr, master, strobe, tc_hit, unused_bits;

    assign active = (bus.dreq | softreq) & ~mask;
    dma_priority #(.NCH(NCH)) u_priority (.req(active), .grant(grant));

    // register accesses only while the CPU owns the bus
    assign slave_sel = state == SI && !bus.hlda && !bus.cs_n;
    assign wr_lvl = slave_sel && !bus.iow_n;
    assign rd_lvl = slave_sel && !bus.ior_n;
    assign wr_go = wr_lvl && !wr_q;
    assign rd_end = rd_q && !rd_lvl;
    assign mclr = wr_go && bus.addr_l == R_MCLR;
    assign wch = bus.addr_l[2:1];
    assign addr = cur_addr[ch];
    assign m = mode[ch];
    assign tc_hit = cur_cnt[ch] == '0 || eop_ext;
    assign unused_bits = ^{m.kind, m.ch, cmd.hi, cmd.lo};
    assign rd_word = bus.addr_l[0] ? cur_cnt[wch] : cur_addr[wch];
    assign rd_data = !bus.addr_l[3] ? (ff ? rd_word[15:8] : rd_word[7:0])
                   : bus.addr_l == R_CMD ? {bus.dreq, tc} : 8'h00;

    always_comb begin
        state_nx = state;
        case (state)
            SI: state_nx = |active && !cmd.ctrl_off ? S0 : SI;
            S0: state_nx = !(|active) ? SI : bus.hlda ? S1 : S0;
            S1: state_nx = S2;
            S2: state_nx = S4;
            default: state_nx = SI;
        endcase
    end

    assign master = state == S1 || state == S2 || state == S4;
    assign strobe = state == S2 && bus.hlda && !abort;
    assign bus.hrq = state != SI;
    assign bus.aen = master;
    assign bus.adstb = state == S1;
    assign bus.dack = master ? 4'b0001 << ch : '0;
    assign bus.addr_u = master ? addr[7:4] : '0;
    assign bus.addr_l_drv = addr[3:0];
    assign bus.addr_l_oe = master;
    assign bus.db_drv = state == S1 ? addr[15:8] : rd_data;
    assign bus.db_oe = state == S1 || rd_lvl;
    assign bus.io_oe = master;
    assign bus.ior_n_drv = !(strobe && m.xfer == XF_WRITE);
    assign bus.iow_n_drv = !(strobe && m.xfer == XF_READ);
    assign bus.memr_n = !(strobe && m.xfer == XF_READ);
    assign bus.memw_n = !(strobe && m.xfer == XF_WRITE);
    assign bus.eop_oe = state == S4 && !abort && tc_hit;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= SI;
            ch <= '0;
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            rd_sel <= '0;
            abort <= 1'b0;
            eop_ext <= 1'b0;
        end else begin
            state <= state_nx;
            wr_q <= wr_lvl;
            rd_q <= rd_lvl;
            if (rd_lvl) rd_sel <= bus.addr_l;
            if (state == S0) ch <= onehot_idx(grant);
            if (state == S0) abort <= 1'b0;
            if ((state == S1 || state == S2) && !bus.hlda) abort <= 1'b1;
            eop_ext <= state == S2 && !bus.eop_n;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cmd <= '0;
            mask <= '1;
            softreq <= '0;
            tc <= '0;
            ff <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                mode[i] <= '0;
                base_addr[i] <= '0;
                cur_addr[i] <= '0;
                base_cnt[i] <= '0;
                cur_cnt[i] <= '0;
            end
        end else if (mclr) begin
            cmd <= '0;
            mask <= '1;
            softreq <= '0;
            tc <= '0;
            ff <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                mode[i] <= '0;
                base_addr[i] <= '0;
                cur_addr[i] <= '0;
                base_cnt[i] <= '0;
                cur_cnt[i] <= '0;
            end
        end else begin
            if (wr_go && !bus.addr_l[3] && bus.addr_l[0]) begin
                base_cnt[wch][{ff, 3'd0} +: 8] <= bus.db;
                cur_cnt[wch][{ff, 3'd0} +: 8] <= bus.db;
            end
            if (wr_go && !bus.addr_l[3] && !bus.addr_l[0]) begin
                base_addr[wch][{ff, 3'd0} +: 8] <= bus.db;
                cur_addr[wch][{ff, 3'd0} +: 8] <= bus.db;
            end
            if (wr_go) begin
                case (bus.addr_l)
                    R_CMD: cmd <= bus.db;
                    R_REQ: softreq[bus.db[1:0]] <= bus.db[2];
                    R_SMASK: mask[bus.db[1:0]] <= bus.db[2];
                    R_MODE: mode[bus.db[1:0]] <= bus.db;
                    R_CLRMASK: mask <= '0;
                    R_MASK: mask <= bus.db[3:0];
                    default: ;
                endcase
            end
            if ((wr_go && !bus.addr_l[3]) || (rd_end && !rd_sel[3])) ff <= !ff;
            if (wr_go && bus.addr_l == R_CLRFF) ff <= 1'b0;
            if (rd_end && rd_sel == R_CMD) tc <= '0;
            // count wraps 0 -> FFFF on terminal count; autoinit then overrides with base
            if (state == S4 && !abort) begin
                cur_addr[ch] <= m.dec ? addr - 1'b1 : addr + 1'b1;
                cur_cnt[ch] <= cur_cnt[ch] - 1'b1;
                if (tc_hit) begin
                    tc[ch] <= 1'b1;
                    softreq[ch] <= 1'b0;
                    if (m.autoinit) begin
                        cur_addr[ch] <= base_addr[ch];
                        cur_cnt[ch] <= base_cnt[ch];
                    end else begin
                        mask[ch] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dma_modport.sv
// tb_dma_modport: scoreboard bench; expected register reads and transfer cycles are queued, monitors compare
module tb_dma_modport;
    typedef struct packed {
        logic [3:0] dack;
        logic [7:0] db;
        logic [3:0] au;
        logic [3:0] al;
        logic [3:0] strb;
        logic       eop;
        logic       partial;
    } xfer_exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic auto_hold = 1'b0;
    int n_pass = 0;
    int n_total = 0;
    int rd_n = 0;
    int x_n = 0;
    logic rd_busy = 1'b0;
    logic [7:0] rq[$];
    xfer_exp_t xq[$];

    dma_modport_if bus();
    dma_modport dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;
    always @(negedge CLK) bus.hlda = auto_hold & bus.hrq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic exp_xfer(input logic [3:0] dack, input logic [7:0] db, input logic [3:0] au,
                            input logic [3:0] al, input logic [3:0] strb, input logic eop, input logic partial);
        xq.push_back('{dack, db, au, al, strb, eop, partial});
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.addr_l = a;
        bus.db = d;
        bus.cs_n = 1'b0;
        bus.iow_n = 1'b0;
        @(negedge CLK);
        bus.iow_n = 1'b1;
        bus.cs_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        rq.push_back(exp);
        bus.addr_l = a;
        bus.cs_n = 1'b0;
        bus.ior_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        bus.ior_n = 1'b1;
        bus.cs_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic wait_done(input int n, input string name);
        int cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (bus.adstb) begin
                cnt++;
                if (cnt == n) bus.dreq = '0;
            end
            if (cnt >= n && !bus.hrq) break;
        end
        check({name, "_done"}, {31'd0, cnt == n && !bus.hrq}, 32'd1);
        auto_hold = 1'b0;
        bus.dreq = '0;
        @(negedge CLK);
    endtask

    task automatic wait_s1(input string name);
        int i = 0;
        while (!bus.adstb && i < 200) begin
            @(negedge CLK);
            i++;
        end
        check({name, "_s1"}, {31'd0, bus.adstb}, 32'd1);
    endtask

    // register-read monitor: one compare per CPU read pulse
    initial forever begin
        @(posedge CLK);
        #1;
        if (bus.db_oe && !bus.aen) begin
            if (!rd_busy) begin
                rd_busy = 1'b1;
                if (rq.size() == 0) check($sformatf("rd%0d_unexpected", rd_n), 32'd1, 32'd0);
                else check($sformatf("rd%0d_db", rd_n), {24'd0, bus.db_drv}, {24'd0, rq.pop_front()});
                rd_n++;
            end
        end else begin
            rd_busy = 1'b0;
        end
    end

    // transfer monitor: S1 address/ack, then S2 strobes, then S4 end-of-process
    initial forever begin
        xfer_exp_t x;
        @(posedge CLK);
        #1;
        if (bus.adstb) begin
            if (xq.size() == 0) begin
                check($sformatf("x%0d_unexpected", x_n), 32'd1, 32'd0);
            end else begin
                x = xq.pop_front();
                check($sformatf("x%0d_dack", x_n), {28'd0, bus.dack}, {28'd0, x.dack});
                check($sformatf("x%0d_db", x_n), {23'd0, bus.db_oe, bus.db_drv}, {23'd0, 1'b1, x.db});
                check($sformatf("x%0d_addr", x_n), {23'd0, bus.aen, bus.addr_u, bus.addr_l_drv}, {23'd0, 1'b1, x.au, x.al});
                if (!x.partial) begin
                    @(posedge CLK);
                    #1;
                    check($sformatf("x%0d_strobes", x_n), {28'd0, bus.ior_n_drv, bus.iow_n_drv, bus.memr_n, bus.memw_n},
                          {28'd0, x.strb});
                    @(posedge CLK);
                    #1;
                    check($sformatf("x%0d_eop", x_n), {31'd0, bus.eop_oe}, {31'd0, x.eop});
                end
            end
            x_n++;
        end
    end

    initial begin
        bus.cs_n = 1'b1;
        bus.ior_n = 1'b1;
        bus.iow_n = 1'b1;
        bus.eop_n = 1'b1;
        bus.db = 8'h00;
        bus.addr_l = 4'h0;
        bus.dreq = '0;
        #1;
        check("rst_hrq_dack_aen", {26'd0, bus.hrq, bus.dack, bus.aen}, 32'd0);
        check("rst_strobes", {30'd0, bus.memr_n, bus.memw_n}, 32'd3);
        check("rst_hiz", {28'd0, bus.db_oe, bus.io_oe, bus.addr_l_oe, bus.eop_oe}, 32'd0);
        check("rst_addr_u", {28'd0, bus.addr_u}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        rd(4'h8, 8'h00);

        // ch1: write IO->mem, 0x1234, count 2
        wr(4'hC, 8'h00);
        wr(4'h2, 8'h34);
        wr(4'h2, 8'h12);
        wr(4'h3, 8'h02);
        wr(4'h3, 8'h00);
        wr(4'hB, 8'h45);
        wr(4'hA, 8'h01);
        rd(4'h2, 8'h34);
        rd(4'h2, 8'h12);
        exp_xfer(4'b0010, 8'h12, 4'h3, 4'h4, 4'b0110, 1'b0, 1'b0);
        exp_xfer(4'b0010, 8'h12, 4'h3, 4'h5, 4'b0110, 1'b0, 1'b0);
        exp_xfer(4'b0010, 8'h12, 4'h3, 4'h6, 4'b0110, 1'b1, 1'b0);
        bus.dreq = 4'b0010;
        auto_hold = 1'b1;
        wait_done(3, "ch1");
        rd(4'h8, 8'h02);
        rd(4'h2, 8'h37);
        rd(4'h2, 8'h12);
        bus.dreq = 4'b0010;
        auto_hold = 1'b1;
        repeat (6) @(negedge CLK);
        check("ch1_masked_hrq", {31'd0, bus.hrq}, 32'd0);
        bus.dreq = '0;
        auto_hold = 1'b0;
        @(negedge CLK);

        // ch0 (mem->IO) and ch2 (verify) requested together, count 0 each
        wr(4'hC, 8'h00);
        wr(4'h0, 8'h00);
        wr(4'h0, 8'h20);
        wr(4'h1, 8'h00);
        wr(4'h1, 8'h00);
        wr(4'h4, 8'h00);
        wr(4'h4, 8'h30);
        wr(4'h5, 8'h00);
        wr(4'h5, 8'h00);
        wr(4'hB, 8'h08);
        wr(4'hB, 8'h02);
        wr(4'hA, 8'h00);
        wr(4'hA, 8'h02);
        exp_xfer(4'b0001, 8'h20, 4'h0, 4'h0, 4'b1001, 1'b1, 1'b0);
        exp_xfer(4'b0100, 8'h30, 4'h0, 4'h0, 4'b1111, 1'b1, 1'b0);
        bus.dreq = 4'b0101;
        auto_hold = 1'b1;
        wait_done(2, "prio");
        rd(4'h8, 8'h05);

        // ch3: autoinit + decrement, count 0, address 0x00FF
        wr(4'hC, 8'h00);
        wr(4'h6, 8'hFF);
        wr(4'h6, 8'h00);
        wr(4'h7, 8'h00);
        wr(4'h7, 8'h00);
        wr(4'hB, 8'h33);
        wr(4'hA, 8'h03);
        exp_xfer(4'b1000, 8'h00, 4'hF, 4'hF, 4'b1111, 1'b1, 1'b0);
        bus.dreq = 4'b1000;
        auto_hold = 1'b1;
        wait_done(1, "auto");
        rd(4'h6, 8'hFF);
        rd(4'h6, 8'h00);
        rd(4'h7, 8'h00);
        rd(4'h7, 8'h00);
        rd(4'h8, 8'h08);

        // ch3: count 5, external EOP during S2 ends it early
        wr(4'hC, 8'h00);
        wr(4'h7, 8'h05);
        wr(4'h7, 8'h00);
        wr(4'hB, 8'h03);
        exp_xfer(4'b1000, 8'h00, 4'hF, 4'hF, 4'b1111, 1'b1, 1'b0);
        bus.dreq = 4'b1000;
        auto_hold = 1'b1;
        wait_s1("eop");
        bus.dreq = '0;
        @(negedge CLK);
        bus.eop_n = 1'b0;
        @(negedge CLK);
        bus.eop_n = 1'b1;
        wait_done(0, "eop");
        rd(4'h8, 8'h08);
        wr(4'hC, 8'h00);
        rd(4'h6, 8'h00);
        rd(4'h6, 8'h01);
        rd(4'h7, 8'h04);
        rd(4'h7, 8'h00);

        // ch2 again, reset asserted in S2
        wr(4'hA, 8'h02);
        exp_xfer(4'b0100, 8'h30, 4'h0, 4'h1, 4'b1111, 1'b0, 1'b1);
        bus.dreq = 4'b0100;
        auto_hold = 1'b1;
        wait_s1("rst");
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("mid_rst_hrq_dack_aen", {26'd0, bus.hrq, bus.dack, bus.aen}, 32'd0);
        check("mid_rst_strobes", {30'd0, bus.memr_n, bus.memw_n}, 32'd3);
        check("mid_rst_hiz", {28'd0, bus.db_oe, bus.io_oe, bus.addr_l_oe, bus.eop_oe}, 32'd0);
        bus.dreq = '0;
        auto_hold = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        rd(4'h8, 8'h00);
        repeat (3) @(negedge CLK);
        check("rq_empty", rq.size(), 32'd0);
        check("xq_empty", xq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
